// File: rtl/fetch_unit_if.sv
// Fetch unit port bundle: redirect input, instruction-memory request/response
// channel and the decode-side instruction handshake.
interface fetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;

   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_data;
   logic [XLEN-1:0] instr_pc;
   logic [6:0]      instr_op;
   logic            instr_illegal;

   // master: the fetch unit; slave: memory, decode and branch logic around it
   modport master (
      input  redirect_valid, redirect_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  instr_ready,
      output imem_req_valid, imem_req_addr,
      output instr_valid, instr_data, instr_pc, instr_op, instr_illegal
   );

   modport slave (
      output redirect_valid, redirect_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output instr_ready,
      input  imem_req_valid, imem_req_addr,
      input  instr_valid, instr_data, instr_pc, instr_op, instr_illegal
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited word fetch, small instruction
// queue toward decode, and redirect handling that drops stale responses.
module fetch_unit #(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned    IQ_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     word;
      logic            illegal;
   } iq_entry_t;

   iq_entry_t        iq_mem [IQ_DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] q_count_q, out_q, drop_q;
   logic [XLEN-1:0]  pc_q, rsp_pc_q;

   logic             head_valid, pop, pop_eff, req_valid, req_fire;
   logic             push, rsp_drop, credit_ok;
   logic [SUM_W-1:0] in_use;
   logic [XLEN-1:0]  redirect_base;

   function automatic logic op_illegal(input logic [31:0] w);
      logic bad;
      bad = 1'b1;
      if (w[1:0] == 2'b11) begin
         unique case (w[6:0])
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111: bad = 1'b0;
            default:                                         bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(IQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshakes and credit: words in flight (dropped ones included) plus queued
   // words never exceed the queue depth, so a response always finds a slot.
   always_comb begin
      head_valid    = (q_count_q != '0);
      pop           = head_valid & bus.instr_ready;
      pop_eff       = pop & ~bus.redirect_valid;
      in_use        = SUM_W'(out_q) + SUM_W'(q_count_q) - SUM_W'(pop);
      credit_ok     = (in_use < SUM_W'(IQ_DEPTH));
      req_valid     = rst_n & ~bus.redirect_valid & credit_ok;
      req_fire      = req_valid & bus.imem_req_ready;
      rsp_drop      = bus.imem_rsp_valid & (drop_q != '0);
      push          = bus.imem_rsp_valid & (drop_q == '0) & ~bus.redirect_valid;
      redirect_base = {bus.redirect_pc[XLEN-1:2], 2'b00};
   end

   always_comb begin
      bus.imem_req_valid = req_valid;
      bus.imem_req_addr  = pc_q;
      bus.instr_valid    = head_valid;
      bus.instr_data     = iq_mem[head_q].word;
      bus.instr_pc       = iq_mem[head_q].pc;
      bus.instr_op       = iq_mem[head_q].word[6:0];
      bus.instr_illegal  = head_valid & iq_mem[head_q].illegal;
   end

   // Pointers, counters and fetch/response PCs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         rsp_pc_q  <= RESET_PC;
         out_q     <= '0;
         drop_q    <= '0;
         q_count_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
      end else begin
         unique case ({req_fire, bus.imem_rsp_valid})
            2'b10:   out_q <= out_q + CNT_W'(1);
            2'b01:   out_q <= out_q - CNT_W'(1);
            default: ;
         endcase

         if (bus.redirect_valid) begin
            // everything still in flight after this cycle belongs to the old path
            pc_q      <= redirect_base;
            rsp_pc_q  <= redirect_base;
            drop_q    <= out_q - CNT_W'(bus.imem_rsp_valid);
            q_count_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
         end else begin
            if (req_fire) pc_q <= pc_q + PC_STEP;
            if (rsp_drop) drop_q <= drop_q - CNT_W'(1);
            if (push) begin
               rsp_pc_q <= rsp_pc_q + PC_STEP;
               tail_q   <= ptr_inc(tail_q);
            end
            if (pop_eff) head_q <= ptr_inc(head_q);
            unique case ({push, pop_eff})
               2'b10:   q_count_q <= q_count_q + CNT_W'(1);
               2'b01:   q_count_q <= q_count_q - CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

   // Queue storage needs no reset; entries are only visible behind q_count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         iq_mem[tail_q] <= {rsp_pc_q, bus.imem_rsp_data, op_illegal(bus.imem_rsp_data)};
      end
   end

   q_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop_eff && (q_count_q == CNT_W'(IQ_DEPTH))));

   rsp_without_req_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.imem_rsp_valid && (out_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised bench for fetch_unit: memory model with in-order
// variable-latency responses and a PC/word scoreboard on the decode side.
module tb_fetch_unit;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned IQ_DEPTH = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(XLEN)) bus();

   fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .IQ_DEPTH(IQ_DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       pend[$];
   logic [31:0] req_addr_log[$];
   int          req_cyc_log[$];
   logic [31:0] pop_pc_log[$];
   logic [31:0] pop_data_log[$];
   logic        pop_ill_log[$];
   int          pop_cyc_log[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int          lat_min = 1, lat_max = 1, rdy_pct = 100, ird_pct = 100, redir_rand_pct = 0;
   bit          hold = 0, redir_req = 0, redir_on_rsp = 0, redir_fired = 0;
   logic [31:0] redir_tgt = '0;
   logic [31:0] exp_pc = '0;
   bit          hold_prev = 0;
   logic [31:0] prev_pc, prev_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] low_byte(input logic [2:0] s);
      case (s)
         3'd0: return 8'h13;
         3'd1: return 8'h33;
         3'd2: return 8'h03;
         3'd3: return 8'h23;
         3'd4: return 8'h63;
         3'd5: return 8'h7F;
         3'd6: return 8'h67;
         default: return 8'h0B;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h200) return 32'h0000_007F;
      if (a == 32'h204) return 32'h0000_0013;
      return {a[25:2], low_byte(a[4:2])};
   endfunction

   function automatic logic exp_ill(input logic [31:0] w);
      case (w[7:0])
         8'h13, 8'h33, 8'h03, 8'h23, 8'h63, 8'h67: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // One clock cycle, entered and left at the falling edge.
   task automatic tick();
      bit          r;
      logic [31:0] w;
      if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'hDEAD_BEEF;
      end
      bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
      bus.instr_ready    = ($urandom_range(99) < ird_pct);
      r = redir_req || (redir_on_rsp && bus.imem_rsp_valid);
      if (!r && redir_rand_pct > 0 && $urandom_range(99) < redir_rand_pct) begin
         r = 1'b1;
         redir_tgt = 32'h1000 + $urandom_range(4095);
      end
      if (r) begin
         redir_fired  = 1'b1;
         redir_req    = 1'b0;
         redir_on_rsp = 1'b0;
      end
      bus.redirect_valid = r;
      bus.redirect_pc    = redir_tgt;
      #1;
      if (hold_prev) begin
         check("hold_valid", bus.instr_valid, 1);
         check("hold_pc", bus.instr_pc, prev_pc);
         check("hold_data", bus.instr_data, prev_data);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         check("credit", pend.size() < IQ_DEPTH, 1);
         pend.push_back('{addr: bus.imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
         req_addr_log.push_back(bus.imem_req_addr);
         req_cyc_log.push_back(cyc);
      end
      if (bus.imem_rsp_valid) void'(pend.pop_front());
      if (bus.instr_valid && bus.instr_ready && !r) begin
         w = mem_word(exp_pc);
         check("sb_pc", bus.instr_pc, exp_pc);
         check("sb_data", bus.instr_data, w);
         check("sb_op", bus.instr_op, w[6:0]);
         check("sb_illegal", bus.instr_illegal, exp_ill(w));
         pop_pc_log.push_back(bus.instr_pc);
         pop_data_log.push_back(bus.instr_data);
         pop_ill_log.push_back(bus.instr_illegal);
         pop_cyc_log.push_back(cyc);
         exp_pc = exp_pc + 32'd4;
      end
      if (r) exp_pc = {redir_tgt[31:2], 2'b00};
      hold_prev = bus.instr_valid && !bus.instr_ready && !r;
      prev_pc   = bus.instr_pc;
      prev_data = bus.instr_data;
      @(negedge clk);
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b0;
      #1;
      check("rst_req_valid", bus.imem_req_valid, 0);
      check("rst_instr_valid", bus.instr_valid, 0);
      pend.delete();
      hold_prev = 0;
      hold = 0; redir_req = 0; redir_on_rsp = 0; redir_rand_pct = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst_hold_instr_valid", bus.instr_valid, 0);
      rst_n  = 1'b1;
      exp_pc = 32'h0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, p0, c0, k;
      @(negedge clk);

      // 1: streaming at one instruction per cycle
      do_reset();
      lat_min = 1; lat_max = 1; rdy_pct = 100; ird_pct = 100;
      n0 = req_addr_log.size(); p0 = pop_pc_log.size(); c0 = cyc;
      ticks(8);
      for (int i = 0; i < 4; i++) begin
         check("t1_req_addr", req_addr_log[n0+i], 32'(4*i));
         check("t1_req_cyc", req_cyc_log[n0+i], c0 + i);
         check("t1_pop_pc", pop_pc_log[p0+i], 32'(4*i));
         check("t1_pop_cyc", pop_cyc_log[p0+i], c0 + 2 + i);
      end

      // 2: decode stalls, credit caps fetch, nothing lost on release
      do_reset();
      ird_pct = 0;
      n0 = req_addr_log.size();
      ticks(10);
      check("t2_nreq", req_addr_log.size() - n0, IQ_DEPTH);
      check("t2_req_valid_low", bus.imem_req_valid, 0);
      check("t2_head_valid", bus.instr_valid, 1);
      check("t2_head_pc", bus.instr_pc, 32'h0);
      ird_pct = 100;
      p0 = pop_pc_log.size();
      ticks(10);
      check("t2_npop", pop_pc_log.size() - p0, 10);
      check("t2_first_pc", pop_pc_log[p0], 32'h0);
      check("t2_last_pc", pop_pc_log[p0+9], 32'h24);

      // 3: redirect with 0x8 and 0xC in flight
      do_reset();
      k = 0;
      while (k < 20 && !(pend.size() == 2 && pend[0].addr == 32'h8 && pend[1].addr == 32'hC)) begin
         tick();
         if (req_addr_log.size() > 0 && req_addr_log[$] == 32'h8) hold = 1;
         k++;
      end
      check("t3_in_flight", pend.size(), 2);
      redir_tgt = 32'h103; redir_req = 1;
      n0 = req_addr_log.size();
      tick();
      check("t3_no_req_on_redirect", req_addr_log.size(), n0);
      hold = 0;
      p0 = pop_pc_log.size();
      ticks(8);
      if (req_addr_log.size() > n0) check("t3_next_req", req_addr_log[n0], 32'h100);
      else check("t3_next_req_missing", 0, 1);
      if (pop_pc_log.size() > p0) check("t3_first_pop", pop_pc_log[p0], 32'h100);
      else check("t3_first_pop_missing", 0, 1);

      // 3b: redirect in the same cycle as a response
      lat_min = 2; lat_max = 2;
      redir_tgt = 32'h300; redir_on_rsp = 1; redir_fired = 0;
      for (int i = 0; i < 20 && !redir_fired; i++) tick();
      check("t3b_fired", redir_fired, 1);
      n0 = req_addr_log.size(); p0 = pop_pc_log.size();
      ticks(10);
      if (req_addr_log.size() > n0) check("t3b_next_req", req_addr_log[n0], 32'h300);
      else check("t3b_next_req_missing", 0, 1);
      if (pop_pc_log.size() > p0) check("t3b_first_pop", pop_pc_log[p0], 32'h300);
      else check("t3b_first_pop_missing", 0, 1);

      // 4: illegal opcode followed by addi
      lat_min = 1; lat_max = 1;
      redir_tgt = 32'h200; redir_req = 1;
      tick();
      p0 = pop_pc_log.size();
      ticks(8);
      if (pop_pc_log.size() > p0 + 1) begin
         check("t4_pc0", pop_pc_log[p0], 32'h200);
         check("t4_data0", pop_data_log[p0], 32'h7F);
         check("t4_ill0", pop_ill_log[p0], 1);
         check("t4_pc1", pop_pc_log[p0+1], 32'h204);
         check("t4_data1", pop_data_log[p0+1], 32'h13);
         check("t4_ill1", pop_ill_log[p0+1], 0);
      end else check("t4_pops_missing", 0, 1);

      // 5: reset mid-stream with a full queue
      ird_pct = 0;
      ticks(6);
      check("t5_pre_valid", bus.instr_valid, 1);
      do_reset();
      lat_min = 1; lat_max = 1; rdy_pct = 100; ird_pct = 100;
      n0 = req_addr_log.size(); c0 = cyc;
      tick();
      if (req_addr_log.size() > n0) begin
         check("t5_restart_addr", req_addr_log[n0], 32'h0);
         check("t5_restart_cyc", req_cyc_log[n0], c0);
      end else check("t5_restart_missing", 0, 1);

      // 6: random latency, backpressure and redirects
      lat_min = 1; lat_max = 4; rdy_pct = 70; ird_pct = 70; redir_rand_pct = 3;
      p0 = pop_pc_log.size();
      ticks(3000);
      check("t6_progress", (pop_pc_log.size() - p0) > 300, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
